// File: rtl/adam_axil_ram_if.sv
// AXI-Lite bus bundle for adam_axil_ram.
//   aw_*, w_*, b_* : write address / data / response channels
//   ar_*, r_*      : read address / response channels
//   master         : drives requests and response-ready
//   slave          : drives request-ready and responses
interface adam_axil_ram_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]            aw_prot;
  logic                  aw_valid;
  logic                  aw_ready;

  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;

  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;

  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]            ar_prot;
  logic                  ar_valid;
  logic                  ar_ready;

  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_addr, ar_prot, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_addr, aw_prot, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready,
    input  ar_addr, ar_prot, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/adam_axil_ram.sv
// AXI-Lite slave SRAM with byte strobes, SLVERR on out-of-range addresses and
// a pause/ack drain handshake for power sequencing.
//   clk       : clock
//   rst       : asynchronous active-low reset
//   srst      : synchronous active-high soft reset (memory contents kept)
//   pause_req : request to quiesce the port
//   pause_ack : registered; high once paused and no transaction is in flight
//   s         : AXI-Lite slave port (adam_axil_ram_if.slave)
// One write and one read may be outstanding at a time, independently.
module adam_axil_ram #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIZE       = 4096,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           srst,
  input  logic           pause_req,
  output logic           pause_ack,
  adam_axil_ram_if.slave s
);

  localparam int unsigned Words   = SIZE / STRB_WIDTH;
  localparam int unsigned AddrLsb = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
  localparam int unsigned IdxW    = (Words > 1) ? $clog2(Words) : 1;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return (64'(a) >= 64'(SIZE));
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return (Words > 1) ? a[AddrLsb +: IdxW] : '0;
  endfunction

  logic [DATA_WIDTH-1:0] mem [Words];

  // Write path state
  logic                  aw_pend_q, aw_pend_d;
  logic [IdxW-1:0]       aw_idx_q, aw_idx_d;
  logic                  aw_oor_q, aw_oor_d;
  logic                  w_pend_q, w_pend_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  b_valid_q, b_valid_d;
  logic [1:0]            b_resp_q, b_resp_d;

  // Read path state
  logic                  r_valid_q, r_valid_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

  logic                  pause_ack_q, pause_ack_d;

  logic run, gate, gate_w, idle;
  logic aw_ready, w_ready, ar_ready;
  logic aw_hs, w_hs, ar_hs;
  logic wr_fire, wr_en;
  logic [IdxW-1:0] ar_idx;

  // Prot fields and the sub-word address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s.aw_prot, s.ar_prot, s.aw_addr, s.ar_addr};

  always_comb begin
    // No handshakes while in reset or during a soft-reset cycle.
    run    = rst & ~srst;
    gate   = pause_req | pause_ack_q;
    // A write with its address already latched may still take its data.
    gate_w = gate & ~aw_pend_q;
    idle   = ~aw_pend_q & ~w_pend_q & ~b_valid_q & ~r_valid_q;

    // Data-first writes may still take their address while paused.
    aw_ready = run & ~aw_pend_q & ~b_valid_q & (~gate | w_pend_q);
    w_ready  = run & ~w_pend_q & ~b_valid_q & ~gate_w;
    ar_ready = run & ~r_valid_q & ~gate;

    aw_hs = s.aw_valid & aw_ready;
    w_hs  = s.w_valid & w_ready;
    ar_hs = s.ar_valid & ar_ready;

    wr_fire = aw_pend_q & w_pend_q;
    wr_en   = wr_fire & ~srst & ~aw_oor_q;
    ar_idx  = word_idx(s.ar_addr);
  end

  always_comb begin
    aw_pend_d   = aw_pend_q;
    aw_idx_d    = aw_idx_q;
    aw_oor_d    = aw_oor_q;
    w_pend_d    = w_pend_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    b_valid_d   = b_valid_q;
    b_resp_d    = b_resp_q;
    r_valid_d   = r_valid_q;
    r_resp_d    = r_resp_q;
    r_data_d    = r_data_q;
    pause_ack_d = pause_req & idle;

    if (aw_hs) begin
      aw_pend_d = 1'b1;
      aw_idx_d  = word_idx(s.aw_addr);
      aw_oor_d  = out_of_range(s.aw_addr);
    end
    if (w_hs) begin
      w_pend_d = 1'b1;
      w_data_d = s.w_data;
      w_strb_d = s.w_strb;
    end

    if (wr_fire) begin
      aw_pend_d = 1'b0;
      w_pend_d  = 1'b0;
      b_valid_d = 1'b1;
      b_resp_d  = aw_oor_q ? RespSlverr : RespOkay;
    end else if (b_valid_q && s.b_ready) begin
      b_valid_d = 1'b0;
    end

    // Memory is sampled before this edge's write lands, so a colliding
    // read returns the old word.
    if (ar_hs) begin
      r_valid_d = 1'b1;
      if (out_of_range(s.ar_addr)) begin
        r_resp_d = RespSlverr;
        r_data_d = '0;
      end else begin
        r_resp_d = RespOkay;
        r_data_d = mem[ar_idx];
      end
    end else if (r_valid_q && s.r_ready) begin
      r_valid_d = 1'b0;
    end

    if (srst) begin
      aw_pend_d   = 1'b0;
      w_pend_d    = 1'b0;
      b_valid_d   = 1'b0;
      b_resp_d    = RespOkay;
      r_valid_d   = 1'b0;
      r_resp_d    = RespOkay;
      r_data_d    = '0;
      pause_ack_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_pend_q   <= 1'b0;
      aw_idx_q    <= '0;
      aw_oor_q    <= 1'b0;
      w_pend_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      b_valid_q   <= 1'b0;
      b_resp_q    <= RespOkay;
      r_valid_q   <= 1'b0;
      r_resp_q    <= RespOkay;
      r_data_q    <= '0;
      pause_ack_q <= 1'b0;
    end else begin
      aw_pend_q   <= aw_pend_d;
      aw_idx_q    <= aw_idx_d;
      aw_oor_q    <= aw_oor_d;
      w_pend_q    <= w_pend_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      b_valid_q   <= b_valid_d;
      b_resp_q    <= b_resp_d;
      r_valid_q   <= r_valid_d;
      r_resp_q    <= r_resp_d;
      r_data_q    <= r_data_d;
      pause_ack_q <= pause_ack_d;
    end
  end

  // Storage is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (w_strb_q[b]) begin
          mem[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
        end
      end
    end
  end

  assign s.aw_ready = aw_ready;
  assign s.w_ready  = w_ready;
  assign s.ar_ready = ar_ready;
  assign s.b_valid  = b_valid_q;
  assign s.b_resp   = b_resp_q;
  assign s.r_valid  = r_valid_q;
  assign s.r_resp   = r_resp_q;
  assign s.r_data   = r_data_q;
  assign pause_ack  = pause_ack_q;

endmodule

// File: tb/tb_adam_axil_ram.sv
module tb_adam_axil_ram;

  logic clk = 1'b0;
  logic rst;
  logic srst;
  logic pause_req;
  logic pause_ack;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];  // {resp, data}

  adam_axil_ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  adam_axil_ram #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .SIZE      (4096)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .srst     (srst),
    .pause_req(pause_req),
    .pause_ack(pause_ack),
    .s        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every cycle a response is valid it must match the
  // head of its queue; the entry retires on the handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.b_valid) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected", 64'(bus.b_valid), 64'd0);
        end else begin
          check("b_resp", 64'(bus.b_resp), 64'(exp_b[0]));
          if (bus.b_ready) void'(exp_b.pop_front());
        end
      end
      if (bus.r_valid) begin
        if (exp_r.size() == 0) begin
          check("r_unexpected", 64'(bus.r_valid), 64'd0);
        end else begin
          check("r_resp_data", 64'({bus.r_resp, bus.r_data}), 64'(exp_r[0]));
          if (bus.r_ready) void'(exp_r.pop_front());
        end
      end
    end
  end

  task automatic bus_xfer(input bit do_aw, input bit do_w, input bit do_ar,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    bit aw_go, w_go, ar_go;
    if (do_aw) begin bus.aw_addr = a; bus.aw_valid = 1'b1; end
    if (do_w)  begin bus.w_data = d; bus.w_strb = st; bus.w_valid = 1'b1; end
    if (do_ar) begin bus.ar_addr = a; bus.ar_valid = 1'b1; end
    for (int i = 0; i < 40 && (bus.aw_valid || bus.w_valid || bus.ar_valid); i++) begin
      @(negedge clk);
      aw_go = bus.aw_valid && bus.aw_ready;
      w_go  = bus.w_valid && bus.w_ready;
      ar_go = bus.ar_valid && bus.ar_ready;
      @(posedge clk); #1;
      if (aw_go) bus.aw_valid = 1'b0;
      if (w_go)  bus.w_valid  = 1'b0;
      if (ar_go) bus.ar_valid = 1'b0;
    end
    check("handshake_done", 64'({bus.aw_valid, bus.w_valid, bus.ar_valid}), 64'd0);
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    bus.ar_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                          input logic [1:0] resp);
    exp_b.push_back(resp);
    bus_xfer(1'b1, 1'b1, 1'b0, a, d, st);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [33:0] exp);
    exp_r.push_back(exp);
    bus_xfer(1'b0, 1'b0, 1'b1, a, 32'd0, 4'd0);
    @(negedge clk);
    check("r_latency", 64'(bus.r_valid), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && (exp_b.size() != 0 || exp_r.size() != 0); i++) @(negedge clk);
    check("drain", 64'(exp_b.size() + exp_r.size()), 64'd0);
    exp_b.delete();
    exp_r.delete();
    @(posedge clk); #1;
  endtask

  task automatic srst_pulse();
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; srst = 1'b0; pause_req = 1'b0;
    bus.aw_addr = '0; bus.aw_prot = '0; bus.aw_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_valid = 1'b0;
    bus.b_ready = 1'b1;
    bus.ar_addr = '0; bus.ar_prot = '0; bus.ar_valid = 1'b0;
    bus.r_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_b_valid", 64'(bus.b_valid), 64'd0);
    check("rst_r_valid", 64'(bus.r_valid), 64'd0);
    check("rst_pause_ack", 64'(pause_ack), 64'd0);
    check("rst_r_data", 64'(bus.r_data), 64'd0);
    check("rst_resps", 64'({bus.b_resp, bus.r_resp}), 64'd0);
    check("rst_readies", 64'({bus.aw_ready, bus.w_ready, bus.ar_ready}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("readies_after_rst", 64'({bus.aw_ready, bus.w_ready, bus.ar_ready}), 64'b111);
    @(posedge clk); #1;

    // Basic write/read with latency checks
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
    @(negedge clk);
    check("b_lat_cycle1", 64'(bus.b_valid), 64'd0);
    @(negedge clk);
    check("b_lat_cycle2", 64'(bus.b_valid), 64'd1);
    wait_drain();
    do_read(32'h10, {2'b00, 32'hDEADBEEF});
    wait_drain();

    // Byte strobes
    do_write(32'h20, 32'h11223344, 4'hF, 2'b00);
    do_write(32'h20, 32'hAABBCCDD, 4'b0101, 2'b00);
    wait_drain();
    do_read(32'h20, {2'b00, 32'h11BB33DD});
    wait_drain();

    // Data before address, b_ready held low
    bus.b_ready = 1'b0;
    exp_b.push_back(2'b00);
    bus_xfer(1'b0, 1'b1, 1'b0, 32'd0, 32'hCAFEF00D, 4'hF);
    repeat (3) begin
      @(negedge clk);
      check("w_alone_no_b", 64'(bus.b_valid), 64'd0);
    end
    @(posedge clk); #1;
    bus_xfer(1'b1, 1'b0, 1'b0, 32'h4, 32'd0, 4'd0);
    repeat (6) @(negedge clk);
    check("b_held", 64'(bus.b_valid), 64'd1);
    check("aw_blocked_by_b", 64'(bus.aw_ready), 64'd0);
    @(posedge clk); #1;
    bus.b_ready = 1'b1;
    wait_drain();
    do_read(32'h4, {2'b00, 32'hCAFEF00D});
    wait_drain();

    // Out of range aliases word 0 but must not touch it
    do_write(32'h0, 32'h0BADC0DE, 4'hF, 2'b00);
    do_write(32'h1000, 32'h55555555, 4'hF, 2'b10);
    wait_drain();
    do_read(32'h1000, {2'b10, 32'h0});
    do_read(32'h0, {2'b00, 32'h0BADC0DE});
    wait_drain();

    // Same-cycle read and write of one word returns the old data
    do_write(32'h40, 32'h1, 4'hF, 2'b00);
    wait_drain();
    do_write(32'h40, 32'h2, 4'hF, 2'b00);
    do_read(32'h40, {2'b00, 32'h1});
    wait_drain();
    do_read(32'h40, {2'b00, 32'h2});
    wait_drain();

    // Pause with a read response pending
    bus.r_ready = 1'b0;
    do_read(32'h10, {2'b00, 32'hDEADBEEF});
    pause_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("pause_ar_ready", 64'(bus.ar_ready), 64'd0);
      check("pause_ack_withheld", 64'(pause_ack), 64'd0);
    end
    @(posedge clk); #1;
    bus.r_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("ack_not_yet", 64'(pause_ack), 64'd0);
    @(negedge clk);
    check("ack_after_r", 64'(pause_ack), 64'd1);
    @(posedge clk); #1;
    pause_req = 1'b0;
    @(negedge clk);
    check("ack_still_high", 64'(pause_ack), 64'd1);
    check("ar_still_gated", 64'(bus.ar_ready), 64'd0);
    @(negedge clk);
    check("ack_dropped", 64'(pause_ack), 64'd0);
    check("ar_resumed", 64'(bus.ar_ready), 64'd1);
    @(posedge clk); #1;
    wait_drain();

    // Pause with address latched, data missing
    exp_b.push_back(2'b00);
    bus_xfer(1'b1, 1'b0, 1'b0, 32'h30, 32'd0, 4'd0);
    pause_req = 1'b1;
    @(negedge clk);
    check("half_aw_ready", 64'(bus.aw_ready), 64'd0);
    check("half_w_ready", 64'(bus.w_ready), 64'd1);
    check("half_ack", 64'(pause_ack), 64'd0);
    @(posedge clk); #1;
    bus_xfer(1'b0, 1'b1, 1'b0, 32'd0, 32'h12345678, 4'hF);
    wait_drain();
    for (int i = 0; i < 10 && !pause_ack; i++) @(negedge clk);
    check("ack_after_b", 64'(pause_ack), 64'd1);
    check("ar_gated_by_ack", 64'(bus.ar_ready), 64'd0);
    @(posedge clk); #1;

    // Soft reset clears valids/ack but not memory
    pause_req = 1'b0;
    srst_pulse();
    @(negedge clk);
    check("srst_valids", 64'({bus.b_valid, bus.r_valid, pause_ack}), 64'd0);
    check("srst_r_data", 64'(bus.r_data), 64'd0);
    @(posedge clk); #1;

    // A dropped address must not pair with later data
    bus_xfer(1'b1, 1'b0, 1'b0, 32'h30, 32'd0, 4'd0);
    srst_pulse();
    bus_xfer(1'b0, 1'b1, 1'b0, 32'd0, 32'hFFFFFFFF, 4'hF);
    repeat (3) begin
      @(negedge clk);
      check("no_orphan_write", 64'(bus.b_valid), 64'd0);
    end
    @(posedge clk); #1;
    srst_pulse();
    do_read(32'h30, {2'b00, 32'h12345678});
    do_read(32'h20, {2'b00, 32'h11BB33DD});
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adam_axil_ram.md
Name: adam_axil_ram

Overview:
AXI-Lite slave SRAM that sits directly downstream of one SoC memory port. Each instance consumes one mem_axil[i] slice, one mem_srst[i] and one mem_pause req/ack pair. It provides byte-strobed word storage, SLVERR on out-of-range accesses, and the pause/ack drain protocol used by the power/sequencing logic.

Parameters:
ADDR_WIDTH, 32, AXI-Lite address width
DATA_WIDTH, 32, data width (8, 16, 32 or 64)
SIZE, 4096, capacity in bytes (power of 2, ≥ DATA_WIDTH/8)
STRB_WIDTH, DATA_WIDTH/8, derived; do not override

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
srst  in  1  synchronous soft reset, active-high
pause_req  in  1  pause request
pause_ack  out  1  pause acknowledge
aw_addr  in  ADDR_WIDTH  write address
aw_prot  in  3  ignored
aw_valid / aw_ready  in / out  1  write-address handshake
w_data  in  DATA_WIDTH  write data
w_strb  in  STRB_WIDTH  byte enables
w_valid / w_ready  in / out  1  write-data handshake
b_resp  out  2  write response
b_valid / b_ready  out / in  1  write-response handshake
ar_addr  in  ADDR_WIDTH  read address
ar_prot  in  3  ignored
ar_valid / ar_ready  in / out  1  read-address handshake
r_data  out  DATA_WIDTH  read data
r_resp  out  2  read response
r_valid / r_ready  out / in  1  read-response handshake

Behaviour:
- Storage: SIZE/STRB_WIDTH words.
  - Word index = addr[log2(SIZE)-1 : log2(STRB_WIDTH)]; low bits ignored.
  - addr ≥ SIZE is out of range: resp 2'b10, no write, r_data = 0. In range: resp 2'b00.
- Reset (rst low, asynchronously) and srst (sampled high at a clk edge):
  - Clear aw_pend, w_pend, b_valid, r_valid and pause_ack.
  - b_resp = 0, r_resp = 0, r_data = 0; all readies 0.
  - Memory contents are not cleared by srst and are undefined after rst.
- Write path (independent of read):
  - aw_ready = !aw_pend && !b_valid && !gate. Handshake latches address into aw_pend.
  - w_ready = !w_pend && !b_valid && !gate_w. Handshake latches data/strb into w_pend.
  - aw and w may arrive in either order or in the same cycle.
  - Cycle after both are pending: apply the write per-byte by w_strb, set b_valid with resp, clear both pend flags.
  - b_valid holds, with b_resp stable, until b_ready. Next aw/w accepted the cycle after the b handshake (one write outstanding).
- Read path:
  - ar_ready = !r_valid && !gate.
  - On handshake, r_valid rises next cycle with r_data/r_resp (1-cycle latency). Held stable until r_ready.
  - Next ar accepted the cycle after the r handshake.
- Same-cycle read and write to the same word: read returns the pre-write data.
- Pause:
  - gate = pause_req || pause_ack.
  - gate_w = gate && !aw_pend, so a half-received write (aw latched, w not) still accepts w. Symmetrically, aw_ready is forced high when w_pend && !aw_pend.
  - idle = !aw_pend && !w_pend && !b_valid && !r_valid.
  - pause_ack (registered) <= pause_req && idle.
  - When pause_req falls, pause_ack falls next cycle; readies resume the cycle after that.
  - Outstanding responses still complete while paused.
- pause_req asserted while a b or r response is pending: pause_ack is withheld until the response handshake, then rises one cycle later.
- srst or rst mid-transaction: the pending response is dropped without a handshake; a half-written word is not written.

Test Plan:
- Write aw_addr 0x10, w_data 0xDEADBEEF, strb 4'hF in the same cycle -> b_valid 2 cycles later with b_resp 0. Read 0x10 -> r_valid 1 cycle after ar handshake, r_data 0xDEADBEEF, r_resp 0.
- Byte strobes: write 0x11223344 to 0x20, then 0xAABBCCDD with strb 4'b0101 -> read 0x20 returns 0x11BB33DD.
- w presented 3 cycles before aw (addr 0x4) -> w_pend holds, write occurs once aw arrives, single b beat. b_ready held low 5 cycles -> b_valid and b_resp stay stable.
- Out of range: write then read addr 0x1000 (SIZE 4096) -> b_resp 2'b10, r_resp 2'b10, r_data 0, and word 0 unchanged.
- Pause: issue ar, hold r_ready low, raise pause_req -> ar_ready 0, pause_ack stays 0. Drop r_ready low time -> pause_ack=1 one cycle after r handshake. Deassert pause_req -> pause_ack 0 next cycle, ar_ready 1 the cycle after.
- Pause with aw latched, w missing -> w still accepted, write completes, b handshake, then pause_ack=1. Then srst pulse -> all valids/acks 0, prior data still readable.
